// File: rtl/reversed_pair_serializer_pkg.sv
// Shared definitions for the reversed pair serializer: state encoding,
// frame width derivation and a width helper for counters.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   function automatic int frame_width(input int data_w);
      return 2 * data_w;
   endfunction

   // Never returns less than 1 so a counter for a single value still has a bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/reversed_pair_serializer_if.sv
// Parallel frame input and serial output of the reversed pair serializer.
// Handshake: a frame moves on a rising edge where in_valid && in_ready; the
// source may hold in_valid high indefinitely and in_ready never depends on it.
interface reversed_pair_serializer_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              ser_data;
   logic              ser_valid;
   logic              ser_sof;
   logic              ser_eof;
   logic              busy;
   logic [CNT_W-1:0]  frame_count;
   logic [1:0]        state;

   modport master (
      output in_valid, in_a, in_b,
      input  in_ready, ser_data, ser_valid, ser_sof, ser_eof, busy, frame_count, state
   );

   modport slave (
      input  in_valid, in_a, in_b,
      output in_ready, ser_data, ser_valid, ser_sof, ser_eof, busy, frame_count, state
   );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register; zeros fill in behind the outgoing bits so
// the output idles low once a frame has drained.
module piso_shift_reg #(
   parameter int WIDTH     = 16,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             dout
);
   logic [WIDTH-1:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
         if (MSB_FIRST != 0) sr <= {sr[WIDTH-2:0], 1'b0};
         else                sr <= {1'b0, sr[WIDTH-1:1]};
      end
   end

   assign dout = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];
endmodule

// File: rtl/reversed_pair_serializer.sv
// Accepts a pair of words as one frame and shifts it out one bit per clock,
// marking first/last bits, with an optional idle gap and a completed-frame counter.
module reversed_pair_serializer
   import serial_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 1,
   parameter int MSB_FIRST  = 1,
   parameter int CNT_W      = 16
) (
   input logic clk,
   input logic rst,
   reversed_pair_serializer_if.slave bus
);
   localparam int FRAME_W  = frame_width(DATA_W);
   localparam int IDX_W    = clog2(FRAME_W);
   localparam int GAP_W    = clog2(GAP_CYCLES + 1);
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   state_t             state;
   state_t             state_next;
   logic [IDX_W-1:0]   idx;
   logic [GAP_W-1:0]   gap_cnt;
   logic               last_bit;
   logic               ready;
   logic               accept;
   logic               shift;
   logic               ser_data;
   logic               ser_valid;
   logic               ser_sof;
   logic               ser_eof;
   logic               busy;
   logic [CNT_W-1:0]   frame_count;
   logic [FRAME_W-1:0] load_word;

   assign last_bit = (state == SHIFT) && (idx == IDX_W'(FRAME_W - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // With no gap, the last-bit cycle doubles as the accept slot for the next frame.
   always_comb begin
      ready      = 1'b0;
      state_next = state;
      case (state)
         IDLE:    ready = 1'b1;
         SHIFT:   ready = last_bit && (GAP_CYCLES == 0);
         default: ready = 1'b0;
      endcase
      ready  = ready && !rst;
      accept = bus.in_valid && ready;
      case (state)
         IDLE: if (accept) state_next = SHIFT;
         SHIFT: begin
            if (last_bit) begin
               if (GAP_CYCLES > 0) state_next = GAP;
               else                state_next = accept ? SHIFT : IDLE;
            end
         end
         GAP:     if (gap_cnt == GAP_W'(GAP_LAST)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign shift     = (state == SHIFT) && !accept;
   assign load_word = (MSB_FIRST != 0) ? {bus.in_a, bus.in_b} : {bus.in_b, bus.in_a};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx         <= '0;
         gap_cnt     <= '0;
         ser_valid   <= 1'b0;
         ser_sof     <= 1'b0;
         ser_eof     <= 1'b0;
         busy        <= 1'b0;
         frame_count <= '0;
      end else begin
         idx         <= (state_next == SHIFT && !accept) ? idx + 1'b1 : '0;
         gap_cnt     <= (state == GAP && state_next == GAP) ? gap_cnt + 1'b1 : '0;
         ser_valid   <= (state_next == SHIFT);
         ser_sof     <= accept;
         ser_eof     <= (state_next == SHIFT) && !accept && (idx == IDX_W'(FRAME_W - 2));
         busy        <= (state_next != IDLE);
         if (last_bit) frame_count <= frame_count + 1'b1;
      end
   end

   piso_shift_reg #(
      .WIDTH     (FRAME_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_piso (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .shift (shift),
      .din   (load_word),
      .dout  (ser_data)
   );

   assign bus.in_ready    = ready;
   assign bus.ser_data    = ser_data;
   assign bus.ser_valid   = ser_valid;
   assign bus.ser_sof     = ser_sof;
   assign bus.ser_eof     = ser_eof;
   assign bus.busy        = busy;
   assign bus.frame_count = frame_count;
   assign bus.state       = state;
endmodule

// File: tb/tb_reversed_pair_serializer.sv
// Bench for reversed_pair_serializer: instance A uses defaults (MSB first, one
// gap cycle, 16-bit count), instance B is LSB first, gapless, 4-bit count.
module tb_reversed_pair_serializer;
   localparam int FW    = 16;
   localparam int GAP_A = 1;
   localparam int GAP_B = 0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reversed_pair_serializer_if #(.DATA_W(8), .CNT_W(16)) ifa ();
   reversed_pair_serializer_if #(.DATA_W(8), .CNT_W(4))  ifb ();

   reversed_pair_serializer #(.DATA_W(8), .GAP_CYCLES(GAP_A), .MSB_FIRST(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa.slave));
   reversed_pair_serializer #(.DATA_W(8), .GAP_CYCLES(GAP_B), .MSB_FIRST(0), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb.slave));

   logic [1:0] drv_valid;
   logic [7:0] drv_a[2];
   logic [7:0] drv_b[2];
   logic [1:0] o_ready, o_data, o_valid, o_sof, o_eof, o_busy;
   logic [15:0] o_cnt[2];

   assign ifa.in_valid = drv_valid[0];
   assign ifa.in_a     = drv_a[0];
   assign ifa.in_b     = drv_b[0];
   assign ifb.in_valid = drv_valid[1];
   assign ifb.in_a     = drv_a[1];
   assign ifb.in_b     = drv_b[1];
   assign o_ready = {ifb.in_ready, ifa.in_ready};
   assign o_data  = {ifb.ser_data, ifa.ser_data};
   assign o_valid = {ifb.ser_valid, ifa.ser_valid};
   assign o_sof   = {ifb.ser_sof, ifa.ser_sof};
   assign o_eof   = {ifb.ser_eof, ifa.ser_eof};
   assign o_busy  = {ifb.busy, ifa.busy};
   assign o_cnt[0] = ifa.frame_count;
   assign o_cnt[1] = {12'd0, ifb.frame_count};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Transmission order of a frame, first bit in the top position.
   function automatic logic [FW-1:0] frame_bits(input logic [7:0] a, input logic [7:0] b, input bit msb);
      logic [FW-1:0] r;
      logic [7:0] w[2];
      w[0] = a;
      w[1] = b;
      r = '0;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 8; i++)
            r[FW-1-(k*8+i)] = msb ? w[k][7-i] : w[k][i];
      return r;
   endfunction

   // Reference model: each accepted frame schedules 16 output bits; the
   // block refuses new frames for a fixed number of cycles after acceptance.
   for (genvar u = 0; u < 2; u++) begin : mon
      localparam int G     = (u == 0) ? GAP_A : GAP_B;
      localparam bit MSB   = (u == 0);
      localparam int CMASK = (u == 0) ? 32'hFFFF : 32'h000F;
      logic [2:0] exp_q[$];
      int blk = 0;
      int cnt = 0;
      always @(negedge clk) begin
         logic [2:0] e;
         logic [FW-1:0] fb;
         logic er, eb, ev;
         if (rst) begin
            exp_q.delete();
            blk = 0;
            cnt = 0;
         end else begin
            er = (blk == 0);
            eb = (exp_q.size() > 0) || (blk > 0);
            if (exp_q.size() > 0) begin
               e  = exp_q.pop_front();
               ev = 1'b1;
            end else begin
               e  = 3'b000;
               ev = 1'b0;
            end
            check($sformatf("mon%0d_cycle", u),
                  {o_valid[u], o_data[u], o_sof[u], o_eof[u], o_ready[u], o_busy[u]},
                  {ev, e, er, eb});
            check($sformatf("mon%0d_count", u), o_cnt[u], 16'(cnt & CMASK));
            if (e[0]) cnt++;
            if (drv_valid[u] && er) begin
               fb = frame_bits(drv_a[u], drv_b[u], MSB);
               for (int i = 0; i < FW; i++) exp_q.push_back({fb[FW-1-i], i == 0, i == FW - 1});
               blk = (G > 0) ? FW + G : FW - 1;
            end else if (blk > 0) begin
               blk--;
            end
         end
      end
   end

   typedef struct {
      logic [7:0]    a;
      logic [7:0]    b;
      logic [FW-1:0] bits;
      bit            scramble;
   } vec_t;
   vec_t tab_a[4];
   vec_t tab_b[4];

   task automatic wait_ready(input int u, output bit ok);
      int n;
      n = 0;
      @(posedge clk); #1;
      while (!o_ready[u] && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      ok = o_ready[u];
   endtask

   task automatic send_one(input int u, input vec_t v, input string tag);
      logic [FW-1:0] bits, sof, eof, vld, rdy;
      bit ok;
      wait_ready(u, ok);
      check({tag, "_ready_wait"}, ok, 1);
      drv_a[u] = v.a;
      drv_b[u] = v.b;
      drv_valid[u] = 1'b1;
      @(posedge clk); #1;
      drv_valid[u] = 1'b0;
      if (v.scramble) begin
         drv_a[u] = 8'hEE;
         drv_b[u] = 8'hEE;
      end
      for (int i = 0; i < FW; i++) begin
         @(negedge clk);
         bits = {bits[FW-2:0], o_data[u]};
         sof  = {sof[FW-2:0], o_sof[u]};
         eof  = {eof[FW-2:0], o_eof[u]};
         vld  = {vld[FW-2:0], o_valid[u]};
         rdy  = {rdy[FW-2:0], o_ready[u]};
      end
      check({tag, "_data"}, bits, v.bits);
      check({tag, "_sof"}, sof, 16'h8000);
      check({tag, "_eof"}, eof, 16'h0001);
      check({tag, "_valid"}, vld, 16'hFFFF);
      check({tag, "_ready_in_shift"}, rdy, (u == 0) ? 16'h0000 : 16'h0001);
      @(negedge clk);
      if (u == 0) begin
         check({tag, "_gap"}, {o_valid[u], o_data[u], o_ready[u], o_busy[u]}, 4'b0001);
         @(negedge clk);
      end
      check({tag, "_idle"}, {o_valid[u], o_ready[u], o_busy[u]}, 3'b010);
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish, got no end, expected end");
      $fatal(1);
   end

   initial begin
      logic [31:0] bits32, sof32, eof32, vld32, rdy32;
      bit ok;
      int neof, pend, cyc;

      tab_a[0] = '{8'hA5, 8'h3C, 16'hA53C, 1'b0};
      tab_a[1] = '{8'h12, 8'h34, 16'h1234, 1'b1};
      tab_a[2] = '{8'h80, 8'h01, 16'h8001, 1'b0};
      tab_a[3] = '{8'hC3, 8'h3C, 16'hC33C, 1'b0};
      tab_b[0] = '{8'h01, 8'h80, 16'h8001, 1'b0};
      tab_b[1] = '{8'h12, 8'h34, 16'h482C, 1'b1};
      tab_b[2] = '{8'hFF, 8'h00, 16'hFF00, 1'b0};
      tab_b[3] = '{8'h0F, 8'hF0, 16'hF00F, 1'b0};

      rst = 1'b1;
      drv_valid = 2'b00;
      for (int u = 0; u < 2; u++) begin
         drv_a[u] = 8'h00;
         drv_b[u] = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         check($sformatf("reset_out%0d", u),
               {o_valid[u], o_data[u], o_sof[u], o_eof[u], o_ready[u], o_busy[u]}, 6'b0);
         check($sformatf("reset_cnt%0d", u), o_cnt[u], 16'd0);
      end
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         send_one(0, tab_a[i], $sformatf("a_vec%0d", i));
         if (i == 0) check("a_count_first", o_cnt[0], 16'd1);
      end
      for (int i = 0; i < 2; i++) send_one(1, tab_b[i], $sformatf("b_vec%0d", i));

      // Gapless back-to-back pair with in_valid held high.
      wait_ready(1, ok);
      check("b2b_ready_wait", ok, 1);
      drv_a[1] = tab_b[2].a;
      drv_b[1] = tab_b[2].b;
      drv_valid[1] = 1'b1;
      @(posedge clk); #1;
      drv_a[1] = tab_b[3].a;
      drv_b[1] = tab_b[3].b;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         bits32 = {bits32[30:0], o_data[1]};
         sof32  = {sof32[30:0], o_sof[1]};
         eof32  = {eof32[30:0], o_eof[1]};
         vld32  = {vld32[30:0], o_valid[1]};
         rdy32  = {rdy32[30:0], o_ready[1]};
         if (i == 15) begin
            @(posedge clk); #1;
            drv_valid[1] = 1'b0;
         end
      end
      check("b2b_data", bits32, {tab_b[2].bits, tab_b[3].bits});
      check("b2b_sof", sof32, 32'h8000_8000);
      check("b2b_eof", eof32, 32'h0001_0001);
      check("b2b_valid", vld32, 32'hFFFF_FFFF);
      check("b2b_ready", rdy32, 32'h0001_0001);
      @(negedge clk);
      check("b2b_idle", {o_valid[1], o_ready[1], o_busy[1]}, 3'b010);
      check("b2b_count", o_cnt[1], 16'd4);

      // Asynchronous reset in the middle of a frame.
      wait_ready(0, ok);
      check("rst_ready_wait", ok, 1);
      drv_a[0] = 8'h5A;
      drv_b[0] = 8'h96;
      drv_valid[0] = 1'b1;
      @(posedge clk); #1;
      drv_valid[0] = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_pre_valid", {o_valid[0], o_busy[0]}, 2'b11);
      #2 rst = 1'b1;
      #1;
      check("rst_async_out", {o_valid[0], o_data[0], o_sof[0], o_eof[0], o_ready[0], o_busy[0]}, 6'b0);
      check("rst_async_cnt", o_cnt[0], 16'd0);
      check("rst_async_b", {o_valid[1], o_ready[1], o_busy[1], o_cnt[1]}, 19'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_held_eof", {o_eof[0], o_valid[0]}, 2'b00);
      rst = 1'b0;
      send_one(0, tab_a[3], "a_after_rst");
      check("a_count_after_rst", o_cnt[0], 16'd1);

      // 4-bit counter wrap over 16 gapless frames.
      neof = 0;
      pend = 0;
      cyc  = 0;
      while ((neof < 16 || pend != 0) && cyc < 600) begin
         @(posedge clk); #1;
         drv_valid[1] = 1'b1;
         drv_a[1] = 8'($urandom_range(0, 255));
         drv_b[1] = 8'($urandom_range(0, 255));
         @(negedge clk);
         if (pend == 15) check("b_wrap_15", o_cnt[1], 16'd15);
         else if (pend == 16) check("b_wrap_16", o_cnt[1], 16'd0);
         pend = 0;
         if (o_eof[1]) begin
            neof++;
            pend = neof;
         end
         cyc++;
      end
      check("b_wrap_frames", neof, 16);
      @(posedge clk); #1;
      drv_valid[1] = 1'b0;

      // Random traffic on both instances against the reference model.
      for (int c = 0; c < 800; c++) begin
         @(posedge clk); #1;
         for (int u = 0; u < 2; u++) begin
            drv_valid[u] = ($urandom_range(0, 3) != 0);
            drv_a[u] = 8'($urandom_range(0, 255));
            drv_b[u] = 8'($urandom_range(0, 255));
         end
      end
      @(posedge clk); #1;
      drv_valid = 2'b00;
      repeat (40) @(negedge clk);
      check("drain_q_a", mon[0].exp_q.size(), 0);
      check("drain_q_b", mon[1].exp_q.size(), 0);
      check("drain_idle", {o_valid, o_busy, o_ready}, 6'b000011);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/reversed_pair_serializer.md
Name: reversed_pair_serializer

Overview:
Downstream stage of the bit-reversal block. It accepts the two reversed bytes (q, w) as one parallel frame through a valid/ready handshake and shifts them out one bit per clock: first word, then second word, with start-of-frame and end-of-frame markers. A configurable idle gap separates frames, and a wrapping counter records completed frames.

Parameters:
DATA_W, 8, width of each input word; frame width FRAME_W = 2*DATA_W.
GAP_CYCLES, 1, idle cycles inserted after each frame's last bit; 0 is legal and allows back-to-back frames.
MSB_FIRST, 1, 1 = each word is sent from its MSB down; 0 = each word is sent from its LSB up.
CNT_W, 16, width of frame_count.

Ports:
clk  input  1  single clock, all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream presents a frame.
in_ready  output  1  block will accept a frame this cycle.
in_a  input  DATA_W  first word, sent first (connects to q).
in_b  input  DATA_W  second word, sent second (connects to w).
ser_data  output  1  serial data bit.
ser_valid  output  1  ser_data is a frame bit.
ser_sof  output  1  high on the first bit of a frame.
ser_eof  output  1  high on the last bit of a frame.
busy  output  1  high in SHIFT or GAP.
frame_count  output  CNT_W  number of completed frames, wrapping.

Behaviour:
- Reset (async, rst=1): state=IDLE, shift register=0, bit index=0, gap counter=0, frame_count=0.
- While rst=1, every output is 0, including in_ready, which is gated low.
- States:
  - IDLE: in_ready=1. Accept when in_valid&&in_ready on a rising edge. Load {in_a,in_b}, go to SHIFT with index 0.
  - SHIFT: one bit per cycle, index 0..FRAME_W-1, ser_valid=1.
  - GAP: lasts GAP_CYCLES cycles, ser_valid=0, in_ready=0, then return to IDLE.
- Latency: first bit (with ser_sof) appears on the cycle after acceptance. ser_eof appears FRAME_W cycles after acceptance.
- Bit order, MSB_FIRST=1: in_a[DATA_W-1]..in_a[0], then in_b[DATA_W-1]..in_b[0].
- Bit order, MSB_FIRST=0: in_a[0]..in_a[DATA_W-1], then in_b[0]..in_b[DATA_W-1].
- Transition after the last bit (index FRAME_W-1):
  - GAP_CYCLES>0: go to GAP.
  - GAP_CYCLES=0: in_ready=1 on that cycle. If a frame is accepted, restart SHIFT at index 0 on the next cycle with no bubble; otherwise go to IDLE.
- in_ready is 0 in SHIFT, except on the last-bit cycle when GAP_CYCLES=0.
- Input data is captured only on acceptance. in_a/in_b changes after that have no effect.
- in_valid may stay high while the block is busy. Nothing is accepted until in_ready=1, and no frame is duplicated or lost.
- ser_data=0 whenever ser_valid=0.
- ser_sof and ser_eof are never high together, since FRAME_W ≥ 2.
- frame_count increments on the rising edge that ends the ser_eof cycle and wraps from all-ones to 0.
- Reset mid-frame: the frame is aborted immediately (asynchronous). No ser_eof and no count increment occur. The first frame after release starts cleanly with ser_sof.
- All outputs are registered, except in_ready, which is decoded from state.

Decomposition:
- Shared package serial_pkg holds:
  - the state encodings IDLE=2'd0, SHIFT=2'd1, GAP=2'd2;
  - the FRAME_W derivation;
  - a clog2 helper for the index and gap counter widths.
- One sub-module, piso_shift_reg: parameterised width and direction, with load and shift enables and async reset. It owns the shift register and ser_data. The FSM, counters and handshake stay in the top level.

Test Plan:
- Defaults, send a=8'hA5, b=8'h3C, accepted at cycle T -> ser_data over T+1..T+16 = 1010_0101_0011_1100; ser_sof only at T+1; ser_eof only at T+16; GAP at T+17; in_ready high again at T+18; frame_count=1.
- MSB_FIRST=0, send a=8'h01, b=8'h80 -> bit 1 = 1, bits 2..15 = 0, bit 16 = 1.
- GAP_CYCLES=0, in_valid held high with two frames (8'hFF/8'h00, then 8'h0F/8'hF0) -> second accept on the first frame's eof cycle; its ser_sof follows immediately; 32 contiguous ser_valid cycles; frame_count=2.
- Set a=8'h12, b=8'h34, then change the inputs to 8'hEE/8'hEE during SHIFT -> output remains 0001_0010_0011_0100; in_ready=0 throughout SHIFT.
- Assert rst asynchronously mid-cycle during bit 5 -> ser_valid, busy and frame_count go to 0 without waiting for a clock edge; no ser_eof; after release, frame 8'hC3/8'h3C serialises correctly with ser_sof.
- CNT_W=4, 16 back-to-back frames -> frame_count reads 15 after the 15th eof and 0 after the 16th.
